// File: rtl/vram_blit_engine.sv
// Block fill / block copy bus initiator for the video RAM slave port.
// Optional abort port and cancel behaviour are enabled by defining VERA_BLIT_ABORT_EN.
module vram_blit_engine #(
   parameter int ADDR_W = 15,
   parameter int LEN_W  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [31:0]       cmd_fill,
   input  logic [3:0]        cmd_bytesel,
   output logic              busy,
   output logic              done,
   output logic              bus_req,
   input  logic              bus_ack,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wrdata,
   output logic [3:0]        bus_wrbytesel,
   output logic              bus_write,
   input  logic [31:0]       bus_rddata
`ifdef VERA_BLIT_ABORT_EN
   ,
   input  logic              abort
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_RD    = 3'd2,
      S_RDATA = 3'd3,
      S_WR    = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_len;
   logic [31:0]       r_fill;
   logic [3:0]        r_bytesel;
   logic [31:0]       r_data;

   logic              w_accept;
   logic              w_grant;
   logic              w_last;
   logic              w_abort;

   assign w_accept = cmd_valid && (r_state == S_IDLE);
   assign w_grant  = bus_req && bus_ack;
   assign w_last   = (r_len == LEN_W'(1));

`ifdef VERA_BLIT_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (cmd_len == '0)
                  w_state_next = S_FIN;
               else if (cmd_op)
                  w_state_next = S_RD;
               else
                  w_state_next = S_FILL;
            end
         end
         S_FILL: begin
            if (w_grant && w_last)
               w_state_next = S_FIN;
         end
         S_RD: begin
            if (w_grant)
               w_state_next = S_RDATA;
         end
         S_RDATA: begin
            w_state_next = S_WR;
         end
         S_WR: begin
            if (w_grant)
               w_state_next = w_last ? S_FIN : S_RD;
         end
         S_FIN: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      // FIN is excluded so a late abort cannot produce a second done pulse
      if (w_abort && (r_state != S_IDLE) && (r_state != S_FIN))
         w_state_next = S_FIN;
   end

   // Output logic
   always_comb begin
      cmd_ready     = (r_state == S_IDLE);
      busy          = (r_state != S_IDLE);
      done          = (r_state == S_FIN);
      bus_req       = 1'b0;
      bus_write     = 1'b0;
      bus_addr      = '0;
      bus_wrdata    = '0;
      bus_wrbytesel = '0;
      case (r_state)
         S_FILL: begin
            bus_req       = 1'b1;
            bus_write     = 1'b1;
            bus_addr      = r_dst;
            bus_wrdata    = r_fill;
            bus_wrbytesel = r_bytesel;
         end
         S_RD: begin
            bus_req  = 1'b1;
            bus_addr = r_src;
         end
         S_WR: begin
            bus_req       = 1'b1;
            bus_write     = 1'b1;
            bus_addr      = r_dst;
            bus_wrdata    = r_data;
            bus_wrbytesel = r_bytesel;
         end
         default: begin
         end
      endcase
   end

   // Command datapath; address increments wrap naturally at ADDR_W bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_fill    <= '0;
         r_bytesel <= '0;
         r_data    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_src     <= cmd_src;
                  r_dst     <= cmd_dst;
                  r_len     <= cmd_len;
                  r_fill    <= cmd_fill;
                  r_bytesel <= cmd_bytesel;
               end
            end
            S_FILL, S_WR: begin
               if (w_grant) begin
                  r_dst <= r_dst + ADDR_W'(1);
                  r_len <= r_len - LEN_W'(1);
               end
            end
            S_RDATA: begin
               r_data <= bus_rddata;
               r_src  <= r_src + ADDR_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_blit_engine.sv
// Scoreboard bench for vram_blit_engine: memory-backed bus model, reference model,
// directed spec scenarios followed by randomized fill/copy commands.
`timescale 1ns/1ps
module tb_vram_blit_engine;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [14:0] cmd_src;
   logic [14:0] cmd_dst;
   logic [14:0] cmd_len;
   logic [31:0] cmd_fill;
   logic [3:0]  cmd_bytesel;
   logic        busy;
   logic        done;
   logic        bus_req;
   logic        bus_ack;
   logic [14:0] bus_addr;
   logic [31:0] bus_wrdata;
   logic [3:0]  bus_wrbytesel;
   logic        bus_write;
   logic [31:0] bus_rddata;
`ifdef VERA_BLIT_ABORT_EN
   logic        abort;
`endif

   vram_blit_engine #(.ADDR_W(15), .LEN_W(15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_src      (cmd_src),
      .cmd_dst      (cmd_dst),
      .cmd_len      (cmd_len),
      .cmd_fill     (cmd_fill),
      .cmd_bytesel  (cmd_bytesel),
      .busy         (busy),
      .done         (done),
      .bus_req      (bus_req),
      .bus_ack      (bus_ack),
      .bus_addr     (bus_addr),
      .bus_wrdata   (bus_wrdata),
      .bus_wrbytesel(bus_wrbytesel),
      .bus_write    (bus_write),
      .bus_rddata   (bus_rddata)
`ifdef VERA_BLIT_ABORT_EN
      ,
      .abort        (abort)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_done;
      logic [14:0] addr;
      logic [31:0] data;
      logic [3:0]  bsel;
   } exp_t;

   exp_t        exp_q[$];
   bit          ack_q[$];
   int          ack_pct;
   int          n_vec;
   int          n_err;
   int          cyc;
   int          last_evt;
   bit          rd_seen;

   logic [31:0] bus_mem [0:32767];
   logic [31:0] ref_mem [0:32767];

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] bs);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (bs[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   // Reference model: a command is an ascending word-by-word sequence of writes, then done.
   task automatic model(input bit op, input logic [14:0] src, input logic [14:0] dst,
                        input logic [14:0] len, input logic [31:0] fill, input logic [3:0] bs);
      exp_t        e;
      logic [14:0] a;
      logic [31:0] d;
      for (int i = 0; i < int'(len); i++) begin
         a = dst + 15'(i);
         d = op ? ref_mem[src + 15'(i)] : fill;
         e.is_done = 1'b0;
         e.addr    = a;
         e.data    = d;
         e.bsel    = bs;
         exp_q.push_back(e);
         ref_mem[a] = merge(ref_mem[a], d, bs);
      end
      e.is_done = 1'b1;
      e.addr    = '0;
      e.data    = '0;
      e.bsel    = '0;
      exp_q.push_back(e);
   endtask

   // Bus slave: access happens on the edge after a req&ack sample; read data valid next cycle.
   logic        bm_go;
   logic        bm_wr;
   logic [14:0] bm_addr;
   logic [31:0] bm_data;
   logic [3:0]  bm_bsel;

   always begin
      @(negedge clk);
      bm_go   = rst_n && bus_req && bus_ack;
      bm_wr   = bus_write;
      bm_addr = bus_addr;
      bm_data = bus_wrdata;
      bm_bsel = bus_wrbytesel;
      @(posedge clk);
      #1;
      if (bm_go) begin
         if (bm_wr) bus_mem[bm_addr] = merge(bus_mem[bm_addr], bm_data, bm_bsel);
         else       bus_rddata = bus_mem[bm_addr];
      end
      if (ack_q.size() > 0) bus_ack = ack_q.pop_front();
      else                  bus_ack = ($urandom_range(0, 99) < ack_pct);
   end

   // Monitor: pops the scoreboard on every write and done, checks stalls and done timing.
   bit          mn_stall;
   logic [14:0] mn_addr;
   logic [31:0] mn_data;
   logic        mn_write;
   exp_t        mn_e;

   always begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         mn_stall = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) last_evt = cyc;
`ifdef VERA_BLIT_ABORT_EN
         if (abort) last_evt = cyc;
`endif
         if (mn_stall) begin
            check("stall_req",   32'(bus_req),   32'd1);
            check("stall_addr",  32'(bus_addr),  32'(mn_addr));
            check("stall_data",  bus_wrdata,     mn_data);
            check("stall_write", 32'(bus_write), 32'(mn_write));
         end
         mn_stall = bus_req && !bus_ack;
         mn_addr  = bus_addr;
         mn_data  = bus_wrdata;
         mn_write = bus_write;
         if (bus_req && bus_ack) begin
            if (bus_write) begin
               if (exp_q.size() == 0 || exp_q[0].is_done) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_write: addr 0x%04h data 0x%08h, want none",
                           bus_addr, bus_wrdata);
               end else begin
                  mn_e = exp_q.pop_front();
                  check("wr_addr",  32'(bus_addr),      32'(mn_e.addr));
                  check("wr_data",  bus_wrdata,         mn_e.data);
                  check("wr_bytesel", 32'(bus_wrbytesel), 32'(mn_e.bsel));
               end
               last_evt = cyc;
            end else begin
               rd_seen = 1'b1;
               check("rd_bytesel", 32'(bus_wrbytesel), 32'd0);
            end
         end
         if (done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
            end else begin
               mn_e = exp_q.pop_front();
               check("done_time", 32'(cyc), 32'(last_evt + 1));
            end
         end
      end
   end

   // All stimulus steps start and end at posedge+2.
   task automatic issue(input bit op, input logic [14:0] src, input logic [14:0] dst,
                        input logic [14:0] len, input logic [31:0] fill, input logic [3:0] bs,
                        input bit hold_busy, input bit use_model);
      int t;
      t = 0;
      while (!cmd_ready && t < 2000) begin
         @(posedge clk); #2;
         t++;
      end
      if (!cmd_ready) begin
         fail_now("cmd_ready_timeout");
         return;
      end
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_src     = src;
      cmd_dst     = dst;
      cmd_len     = len;
      cmd_fill    = fill;
      cmd_bytesel = bs;
      if (use_model) model(op, src, dst, len, fill, bs);
      @(posedge clk); #2;
      if (hold_busy) begin
         check("busy_after_accept", 32'(busy),      32'd1);
         check("ready_while_busy",  32'(cmd_ready), 32'd0);
         cmd_op   = 1'b0;
         cmd_dst  = 15'h0555;
         cmd_len  = 15'd5;
         cmd_fill = 32'hDEADBEEF;
         repeat (2) begin
            @(posedge clk); #2;
            check("ready_while_busy", 32'(cmd_ready), 32'd0);
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(output int t);
      t = 0;
      while ((exp_q.size() != 0 || !cmd_ready) && t < 3000) begin
         @(posedge clk); #2;
         t++;
      end
      if (t >= 3000) begin
         fail_now("completion_timeout");
         exp_q.delete();
      end
   endtask

   int          lat;
   logic [14:0] r_src_v;
   logic [14:0] r_dst_v;
   logic [14:0] r_len_v;

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; last_evt = 0; rd_seen = 1'b0;
      ack_pct = 100;
      for (int i = 0; i < 32768; i++) begin
         bus_mem[i] = $urandom;
         ref_mem[i] = bus_mem[i];
      end
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
      cmd_len = '0; cmd_fill = '0; cmd_bytesel = '0; bus_ack = 1'b1; bus_rddata = '0;
`ifdef VERA_BLIT_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy",    32'(busy),          32'd0);
      check("rst_done",    32'(done),          32'd0);
      check("rst_req",     32'(bus_req),       32'd0);
      check("rst_write",   32'(bus_write),     32'd0);
      check("rst_addr",    32'(bus_addr),      32'd0);
      check("rst_wrdata",  bus_wrdata,         32'd0);
      check("rst_bytesel", 32'(bus_wrbytesel), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #2;

      // Fill of four words at full throughput
      issue(1'b0, 15'h0000, 15'h0010, 15'd4, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b1);
      wait_idle(lat);
      check("fill_latency", 32'(lat), 32'd5);

      // Two-word copy
      bus_mem[15'h0100] = 32'h11223344; ref_mem[15'h0100] = 32'h11223344;
      bus_mem[15'h0101] = 32'h55667788; ref_mem[15'h0101] = 32'h55667788;
      issue(1'b1, 15'h0100, 15'h0200, 15'd2, 32'h0, 4'hF, 1'b0, 1'b1);
      wait_idle(lat);
      check("copy_latency", 32'(lat), 32'd7);
      check("copy_mem0", bus_mem[15'h0200], 32'h11223344);
      check("copy_mem1", bus_mem[15'h0201], 32'h55667788);

      // Backpressure pattern
      ack_q.push_back(1'b1); ack_q.push_back(1'b0); ack_q.push_back(1'b0);
      ack_q.push_back(1'b1); ack_q.push_back(1'b0); ack_q.push_back(1'b1);
      issue(1'b0, 15'h0000, 15'h0300, 15'd3, 32'h3C3C0F0F, 4'hF, 1'b0, 1'b1);
      wait_idle(lat);
      check("backpressure_latency", 32'(lat), 32'd7);

      // Address wrap and partial byte selects
      issue(1'b0, 15'h0000, 15'h7FFE, 15'd3, 32'h12345678, 4'h5, 1'b0, 1'b1);
      wait_idle(lat);

      // Zero length, then a command held valid while busy
      issue(1'b0, 15'h0000, 15'h0400, 15'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1);
      wait_idle(lat);
      check("len0_latency", 32'(lat), 32'd1);
      issue(1'b0, 15'h0000, 15'h0500, 15'd6, 32'h0BADF00D, 4'hF, 1'b1, 1'b1);
      wait_idle(lat);

      // Randomized commands under varying grant rates
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       ack_pct = 100;
            1:       ack_pct = 60;
            default: ack_pct = 30;
         endcase
         r_len_v = ($urandom_range(0, 6) == 0) ? 15'd0 : 15'($urandom_range(1, 8));
         r_src_v = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFA + 15'($urandom_range(0, 5)))
                                               : 15'($urandom);
         if ($urandom_range(0, 2) == 0)
            r_dst_v = r_src_v + 15'($urandom_range(0, 4));
         else
            r_dst_v = 15'($urandom);
         issue(1'($urandom_range(0, 1)), r_src_v, r_dst_v, r_len_v, $urandom,
               4'($urandom), 1'b0, 1'b1);
         wait_idle(lat);
      end
      ack_pct = 100;

`ifdef VERA_BLIT_ABORT_EN
      // Abort while the read word is in flight: no write, done still pulses
      begin
         exp_t e;
         int   t;
         e.is_done = 1'b1; e.addr = '0; e.data = '0; e.bsel = '0;
         exp_q.push_back(e);
         rd_seen = 1'b0;
         issue(1'b1, 15'h0600, 15'h0700, 15'd3, 32'h0, 4'hF, 1'b0, 1'b0);
         t = 0;
         while (!rd_seen && t < 100) begin
            @(posedge clk); #2;
            t++;
         end
         if (!rd_seen) fail_now("abort_read_timeout");
         abort = 1'b1;
         @(posedge clk); #2;
         abort = 1'b0;
         wait_idle(lat);
         check("abort_no_write", bus_mem[15'h0700], ref_mem[15'h0700]);
      end
`endif

      // Reset in the middle of a copy: outputs clear, no done afterwards
      issue(1'b1, 15'h0800, 15'h0900, 15'd6, 32'h0, 4'hF, 1'b0, 1'b1);
      repeat (4) begin
         @(posedge clk); #2;
      end
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_busy",    32'(busy),          32'd0);
      check("midrst_done",    32'(done),          32'd0);
      check("midrst_req",     32'(bus_req),       32'd0);
      check("midrst_write",   32'(bus_write),     32'd0);
      check("midrst_addr",    32'(bus_addr),      32'd0);
      check("midrst_bytesel", 32'(bus_wrbytesel), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #2;
      end
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_busy",  32'(busy),      32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
